// File: rtl/serial_frame_rx_if.sv
// Consumer-side bundle of the serial frame receiver: byte handshake plus status flags.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface serial_frame_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_ovr;
    logic       rx_busy;

    modport master (
        output rx_data, rx_valid, rx_perr, rx_ferr, rx_ovr, rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_perr, rx_ferr, rx_ovr, rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Receiver for the 11-bit serial frame (start, 8 data bits MSB first, check, stop), one bit per CLK.
// Good bytes go to a one-deep holding register that is drained by a valid/ready consumer.
module serial_frame_rx #(
    parameter int CHK_MODE = 0
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               rx_in,
    serial_frame_rx_if.master  bus
);

    typedef enum logic [2:0] {IDLE, DATA, CHK, STOP, BRK} state_t;

    state_t     state, state_nx;
    logic [2:0] count, count_nx;
    logic [7:0] shreg, shreg_nx;
    logic       chk_err, chk_err_nx;
    logic [7:0] data_q, data_nx;
    logic       valid_q, valid_nx;
    logic       perr_q, perr_nx;
    logic       ferr_q, ferr_nx;
    logic       ovr_q, ovr_nx;
    logic       chk_exp;

    // Check bit the transmitter should have sent for the byte now in the shift register
    always_comb begin
        chk_exp = ~shreg[0];
        if (CHK_MODE == 1) begin
            chk_exp = ^shreg;
        end else if (CHK_MODE == 2) begin
            chk_exp = ~^shreg;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            count   <= 3'd0;
            shreg   <= 8'h00;
            chk_err <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            shreg   <= shreg_nx;
            chk_err <= chk_err_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            perr_q  <= perr_nx;
            ferr_q  <= ferr_nx;
            ovr_q   <= ovr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        shreg_nx   = shreg;
        chk_err_nx = chk_err;
        data_nx    = data_q;
        perr_nx    = perr_q;
        valid_nx   = valid_q & ~bus.rx_ready;
        ferr_nx    = 1'b0;
        ovr_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_in) begin
                    state_nx = DATA;
                    count_nx = 3'd0;
                end
            end
            DATA: begin
                shreg_nx = {shreg[6:0], rx_in};
                if (count == 3'd7) begin
                    state_nx = CHK;
                    count_nx = 3'd0;
                end else begin
                    count_nx = count + 3'd1;
                end
            end
            CHK: begin
                chk_err_nx = (rx_in != chk_exp);
                state_nx   = STOP;
            end
            STOP: begin
                // A slot freed by an accept on this same edge can take the new byte
                if (rx_in) begin
                    state_nx = IDLE;
                    if (!valid_q || bus.rx_ready) begin
                        data_nx  = shreg;
                        perr_nx  = chk_err;
                        valid_nx = 1'b1;
                    end else begin
                        ovr_nx = 1'b1;
                    end
                end else begin
                    ferr_nx  = 1'b1;
                    state_nx = BRK;
                end
            end
            BRK: begin
                if (rx_in) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;
    assign bus.rx_perr  = perr_q;
    assign bus.rx_ferr  = ferr_q;
    assign bus.rx_ovr   = ovr_q;
    assign bus.rx_busy  = (state != IDLE);

endmodule
